count_stream_checker: RTL and testbench

Receive-side companion to the 8-bit free-running counter outputs on the pad ring. Samples an incoming counter stream and checks that every new value is the previous value plus one, modulo 2^WIDTH. It locks after a run of good samples and counts sequence errors. It is used on the receiving chip/pads to qualify the counter link and as a bring-up self-test.

---
 rtl/count_stream_checker.sv | 145 ++++++++++++++
 tb/tb_count_stream_checker.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_stream_checker.sv
// count_stream_checker
// Receive-side checker for an incrementing counter stream. Each qualified
// sample must equal the previous sample plus one (mod 2^WIDTH). The checker
// locks after LOCK_COUNT consecutive good increments. While locked, every
// sequence error is pulsed, made sticky and counted (saturating).
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   data_in      - counter value under check (same clock domain)
//   sample_in    - qualifies data_in this cycle
//   clear_in     - synchronous clear of err_count_o / err_sticky_o
//   locked_o     - high while in LOCKED
//   err_pulse_o  - one-cycle pulse per error detected while LOCKED
//   err_sticky_o - set by any error, held until clear_in or reset
//   err_count_o  - saturating count of errors detected while LOCKED
//   last_value_o - most recent sampled data_in
module count_stream_checker #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ERR_W      = 8,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sample_in,
    input  logic             clear_in,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic             err_sticky_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [WIDTH-1:0] last_value_o
);

    localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);

    // LOCKED owns bit 1 alone so locked_o is a direct flop bit.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_LOCKED  = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [WIDTH-1:0]   last_value_q, last_value_d;
    logic               err_pulse_q, err_pulse_d;
    logic               err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    logic [WIDTH-1:0]   expected;
    logic [CNT_W-1:0]   cnt_inc;
    logic               match;
    logic               seq_err;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            match_cnt_q  <= '0;
            last_value_q <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            match_cnt_q  <= match_cnt_d;
            last_value_q <= last_value_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    // Next-state, lock counting and error bookkeeping.
    always_comb begin
        state_d      = state_q;
        match_cnt_d  = match_cnt_q;
        last_value_d = last_value_q;
        err_pulse_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        seq_err      = 1'b0;

        // Increment wraps naturally in WIDTH bits, so max -> 0 is a match.
        expected = last_value_q + WIDTH'(1);
        match    = (data_in == expected);
        cnt_inc  = match_cnt_q + CNT_W'(1);

        if (sample_in) begin
            last_value_d = data_in;
            case (state_q)
                ST_IDLE: begin
                    // First sample only establishes the reference.
                    state_d     = ST_ACQUIRE;
                    match_cnt_d = '0;
                end
                ST_ACQUIRE: begin
                    if (match) begin
                        if (cnt_inc == CNT_W'(LOCK_COUNT)) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = cnt_inc;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!match) begin
                        seq_err     = 1'b1;
                        state_d     = ST_ACQUIRE;
                        match_cnt_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    match_cnt_d = '0;
                end
            endcase
        end

        if (seq_err) begin
            err_pulse_d  = 1'b1;
            err_sticky_d = 1'b1;
            if (err_count_q != {ERR_W{1'b1}}) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
        end

        // Clear takes priority over a same-cycle error for count and sticky.
        if (clear_in) begin
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end
    end

    assign locked_o     = state_q[1];
    assign err_pulse_o  = err_pulse_q;
    assign err_sticky_o = err_sticky_q;
    assign err_count_o  = err_count_q;
    assign last_value_o = last_value_q;

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench for count_stream_checker. Main instance uses LOCK_COUNT=4,
// ERR_W=2 so saturation is reachable; a LOCK_COUNT=1 instance shares inputs.
module tb_count_stream_checker;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       sample_in;
    logic       clear_in;

    logic       locked;
    logic       err_pulse;
    logic       err_sticky;
    logic [1:0] err_count;
    logic [7:0] last_value;

    logic       locked1;
    logic       err_pulse1;
    logic       err_sticky1;
    logic [7:0] err_count1;
    logic [7:0] last_value1;

    int checks;
    int errors;

    count_stream_checker #(.WIDTH(8), .ERR_W(2), .LOCK_COUNT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .sample_in    (sample_in),
        .clear_in     (clear_in),
        .locked_o     (locked),
        .err_pulse_o  (err_pulse),
        .err_sticky_o (err_sticky),
        .err_count_o  (err_count),
        .last_value_o (last_value)
    );

    count_stream_checker #(.WIDTH(8), .ERR_W(8), .LOCK_COUNT(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .sample_in    (sample_in),
        .clear_in     (clear_in),
        .locked_o     (locked1),
        .err_pulse_o  (err_pulse1),
        .err_sticky_o (err_sticky1),
        .err_count_o  (err_count1),
        .last_value_o (last_value1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let one rising edge take them, settle 1ns.
    task automatic step(input logic s, input logic [7:0] d, input logic c);
        sample_in = s;
        data_in   = d;
        clear_in  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        sample_in = 1'b0;
        data_in   = 8'h00;
        clear_in  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        sample_in = 1'b0;
        data_in   = 8'h00;
        clear_in  = 1'b0;
        #2;
        checks++;
        if ({locked, err_pulse, err_sticky, err_count, last_value} !== 13'd0) begin
            errors++;
            $display("FAIL reset_main got %b required 0",
                     {locked, err_pulse, err_sticky, err_count, last_value});
        end
        checks++;
        if ({locked1, err_pulse1, err_sticky1, err_count1, last_value1} !== 19'd0) begin
            errors++;
            $display("FAIL reset_lc1 got %b required 0",
                     {locked1, err_pulse1, err_sticky1, err_count1, last_value1});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        apply_reset();
        step(1'b1, 8'd10, 1'b0);
        step(1'b1, 8'd11, 1'b0);
        checks++;
        if (locked1 !== 1'b1) begin
            errors++;
            $display("FAIL lock_lc1 got %b required 1", locked1);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early_11 got %b required 0", locked);
        end
        step(1'b1, 8'd12, 1'b0);
        step(1'b1, 8'd13, 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early_13 got %b required 0", locked);
        end
        step(1'b1, 8'd14, 1'b0);
        checks++;
        if ({locked, err_count, last_value} !== {1'b1, 2'd0, 8'd14}) begin
            errors++;
            $display("FAIL lock_at_14 got locked=%b cnt=%0d last=%0d required 1 0 14",
                     locked, err_count, last_value);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        step(1'b1, 8'd252, 1'b0);
        step(1'b1, 8'd253, 1'b0);
        step(1'b1, 8'd254, 1'b0);
        step(1'b1, 8'd255, 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL wrap_early got %b required 0", locked);
        end
        step(1'b1, 8'd0, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL wrap_lock got %b required 1", locked);
        end
        step(1'b1, 8'd1, 1'b0);
        step(1'b1, 8'd2, 1'b0);
        checks++;
        if ({locked, err_sticky, err_count, last_value} !== {1'b1, 1'b0, 2'd0, 8'd2}) begin
            errors++;
            $display("FAIL wrap_end got locked=%b sticky=%b cnt=%0d last=%0d required 1 0 0 2",
                     locked, err_sticky, err_count, last_value);
        end
    endtask

    task automatic test_error_relock();
        apply_reset();
        for (int v = 46; v <= 50; v++) step(1'b1, 8'(v), 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL err_prelock got %b required 1", locked);
        end
        step(1'b1, 8'd60, 1'b0);
        checks++;
        if ({err_pulse, err_count, err_sticky, locked, last_value} !==
            {1'b1, 2'd1, 1'b1, 1'b0, 8'd60}) begin
            errors++;
            $display("FAIL err_detect got pulse=%b cnt=%0d sticky=%b locked=%b last=%0d required 1 1 1 0 60",
                     err_pulse, err_count, err_sticky, locked, last_value);
        end
        step(1'b1, 8'd61, 1'b0);
        checks++;
        if ({err_pulse, locked} !== 2'b00) begin
            errors++;
            $display("FAIL err_pulse_width got pulse=%b locked=%b required 0 0", err_pulse, locked);
        end
        step(1'b1, 8'd62, 1'b0);
        step(1'b1, 8'd63, 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_early got %b required 0", locked);
        end
        step(1'b1, 8'd64, 1'b0);
        checks++;
        if ({locked, err_sticky, err_count} !== {1'b1, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL relock got locked=%b sticky=%b cnt=%0d required 1 1 1",
                     locked, err_sticky, err_count);
        end
    endtask

    task automatic test_acquire_alternating();
        logic [7:0] seq [10];
        logic       any_lock;
        seq = '{8'd5, 8'd6, 8'd9, 8'd10, 8'd3, 8'd4, 8'd0, 8'd1, 8'd7, 8'd8};
        apply_reset();
        any_lock = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, seq[i], 1'b0);
            any_lock = any_lock | locked;
        end
        checks++;
        if ({any_lock, err_count, err_sticky, last_value} !== {1'b0, 2'd0, 1'b0, 8'd8}) begin
            errors++;
            $display("FAIL acquire_alt got anylock=%b cnt=%0d sticky=%b last=%0d required 0 0 0 8",
                     any_lock, err_count, err_sticky, last_value);
        end
    endtask

    task automatic test_gap();
        logic [7:0] garbage [3];
        garbage = '{8'hAA, 8'h55, 8'h00};
        apply_reset();
        for (int v = 16; v <= 20; v++) step(1'b1, 8'(v), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, garbage[i], 1'b0);
            checks++;
            if ({locked, err_pulse, last_value} !== {1'b1, 1'b0, 8'd20}) begin
                errors++;
                $display("FAIL gap_hold_%0d got locked=%b pulse=%b last=%0d required 1 0 20",
                         i, locked, err_pulse, last_value);
            end
        end
        step(1'b1, 8'd21, 1'b0);
        checks++;
        if ({locked, err_sticky, err_count, last_value} !== {1'b1, 1'b0, 2'd0, 8'd21}) begin
            errors++;
            $display("FAIL gap_resume got locked=%b sticky=%b cnt=%0d last=%0d required 1 0 0 21",
                     locked, err_sticky, err_count, last_value);
        end
    endtask

    task automatic test_saturate_clear_async();
        logic [7:0] v;
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        apply_reset();
        for (int i = 100; i <= 104; i++) step(1'b1, 8'(i), 1'b0);
        v = 8'd104;
        for (int e = 0; e < 5; e++) begin
            v = v + 8'd10;
            step(1'b1, v, 1'b0);
            checks++;
            if ({err_pulse, err_count} !== {1'b1, exp_cnt[e]}) begin
                errors++;
                $display("FAIL sat_err_%0d got pulse=%b cnt=%0d required 1 %0d",
                         e, err_pulse, err_count, exp_cnt[e]);
            end
            for (int k = 0; k < 4; k++) begin
                v = v + 8'd1;
                step(1'b1, v, 1'b0);
            end
        end
        checks++;
        if ({locked, err_sticky, err_count} !== {1'b1, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL sat_hold got locked=%b sticky=%b cnt=%0d required 1 1 3",
                     locked, err_sticky, err_count);
        end
        v = v + 8'd10;
        step(1'b1, v, 1'b1);
        checks++;
        if ({err_pulse, err_count, err_sticky, locked} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clear_vs_err got pulse=%b cnt=%0d sticky=%b locked=%b required 1 0 0 0",
                     err_pulse, err_count, err_sticky, locked);
        end
        clear_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v = v + 8'd1;
            step(1'b1, v, 1'b0);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL prereset_lock got %b required 1", locked);
        end
        sample_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, last_value} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL async_reset got locked=%b last=%0d required 0 0", locked, last_value);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lock();
        test_wrap();
        test_error_relock();
        test_acquire_alternating();
        test_gap();
        test_saturate_clear_async();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
